// File: rtl/cpu_out_uart_pkg.sv
// Shared definitions for the OUT-port serial transmitter: FSM state encoding
// and 8N1 frame constants.
package cpu_out_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/cpu_out_uart_byte_fifo.sv
// Single-clock byte FIFO between the core's OUT writes and the serialiser.
// Writes while full are dropped and latch a sticky overflow flag.
module byte_fifo #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop_ok;
    logic [AW:0]   level_nxt;

    // Acceptance uses the registered full, so a pop on the same edge never frees room.
    assign push   = wr_en && !full;
    assign pop_ok = pop && (level != '0);
    assign head   = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (push && !pop_ok)
            level_nxt = level + (AW+1)'(1);
        else if (!push && pop_ok)
            level_nxt = level - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cpu_out_uart.sv
// OUT-port transmitter: buffers core writes and sends each byte as 8N1 serial on tx.
//   state | meaning
//   IDLE  | line high, pop next byte when FIFO is non-empty
//   START | line low for one bit time
//   DATA  | shift out 8 data bits, LSB first
//   STOP  | line high for one bit time, then back to IDLE
module cpu_out_uart
    import cpu_out_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic [FIFO_AW:0]   level,
    output logic               busy,
    output logic               overflow,
    output logic               tx
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t     state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    head;
    logic          pop;
    logic          baud_done;

    assign pop       = (state == ST_IDLE) && (level != '0);
    assign baud_done = (baud == BAUD_LAST);

    byte_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    baud    <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shift_reg <= head;
                        state     <= ST_START;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= ST_DATA;
                        tx    <= shift_reg[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud      <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            // next bit is what lands in shift_reg[0] on this edge
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_out_uart.sv
// Directed bench for cpu_out_uart with CLKS_PER_BIT=4 and a 4-deep FIFO;
// expected line bits and FIFO levels are hand-derived per step.
module tb_cpu_out_uart;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int FRAME = 10 * CPB;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic [AW:0] level;
    logic        busy;
    logic        overflow;
    logic        tx;

    int total = 0;
    int bad   = 0;

    cpu_out_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; writes wr_data on the next edge.
    task automatic write_one(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Checks tx from frame cycle 'skip' to the end; returns #1 after the STOP-end edge.
    task automatic expect_frame(input logic [7:0] b, input int skip);
        for (int t = skip; t < FRAME; t++) begin
            int   bi;
            logic e;
            bi = t / CPB;
            if (bi == 0)      e = 1'b0;
            else if (bi == 9) e = 1'b1;
            else              e = b[bi-1];
            chk($sformatf("frame_%02h_t%0d", b, t), {31'd0, tx}, {31'd0, e});
            tick();
        end
    endtask

    initial begin
        logic [7:0] b;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        #12;
        chk("rst_tx",       {31'd0, tx},       32'd1);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_level",    {29'd0, level},    32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        tick();
        tick();

        // single byte 0xA5
        write_one(8'hA5);
        chk("single_level_k",  {29'd0, level}, 32'd1);
        chk("single_tx_k",     {31'd0, tx},    32'd1);
        chk("single_busy_k",   {31'd0, busy},  32'd0);
        tick();
        chk("single_busy_k1",  {31'd0, busy},  32'd1);
        chk("single_level_k1", {29'd0, level}, 32'd0);
        expect_frame(8'hA5, 0);
        chk("single_busy_end", {31'd0, busy},  32'd0);
        chk("single_tx_end",   {31'd0, tx},    32'd1);
        tick();
        tick();

        // burst 0x01..0x04: pop during the burst keeps level below full
        wr_en = 1'b1;
        wr_data = 8'h01; tick();
        chk("burst_level_1", {29'd0, level}, 32'd1);
        wr_data = 8'h02; tick();
        chk("burst_level_2", {29'd0, level}, 32'd1);
        chk("burst_tx_fall", {31'd0, tx},    32'd0);
        wr_data = 8'h03; tick();
        chk("burst_level_3", {29'd0, level}, 32'd2);
        wr_data = 8'h04; tick();
        chk("burst_level_4", {29'd0, level}, 32'd3);
        chk("burst_full",    {31'd0, full},  32'd0);
        wr_en = 1'b0;
        expect_frame(8'h01, 2);
        for (int k = 2; k <= 4; k++) begin
            chk($sformatf("burst_gap_tx_%0d", k),    {31'd0, tx},    32'd1);
            chk($sformatf("burst_gap_busy_%0d", k),  {31'd0, busy},  32'd0);
            chk($sformatf("burst_gap_level_%0d", k), {29'd0, level}, 32'(5 - k));
            tick();
            b = 8'(k);
            expect_frame(b, 0);
        end
        chk("burst_end_level", {29'd0, level}, 32'd0);
        chk("burst_end_busy",  {31'd0, busy},  32'd0);
        tick();
        tick();

        // overflow: 6 writes, 0x21..0x25 accepted, 0x26 dropped
        wr_en = 1'b1;
        wr_data = 8'h21; tick();
        chk("ovf_level_1", {29'd0, level}, 32'd1);
        wr_data = 8'h22; tick();
        chk("ovf_level_2", {29'd0, level}, 32'd1);
        wr_data = 8'h23; tick();
        chk("ovf_level_3", {29'd0, level}, 32'd2);
        wr_data = 8'h24; tick();
        chk("ovf_level_4", {29'd0, level}, 32'd3);
        chk("ovf_full_4",  {31'd0, full},  32'd0);
        wr_data = 8'h25; tick();
        chk("ovf_level_5", {29'd0, level},    32'd4);
        chk("ovf_full_5",  {31'd0, full},     32'd1);
        chk("ovf_flag_5",  {31'd0, overflow}, 32'd0);
        wr_data = 8'h26; tick();
        chk("ovf_level_6", {29'd0, level},    32'd4);
        chk("ovf_flag_6",  {31'd0, overflow}, 32'd1);
        wr_en = 1'b0;
        expect_frame(8'h21, 4);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("ovf_gap_tx_%0d", k),    {31'd0, tx},    32'd1);
            chk($sformatf("ovf_gap_level_%0d", k), {29'd0, level}, 32'(6 - k));
            tick();
            b = 8'h20 + 8'(k);
            expect_frame(b, 0);
        end
        chk("ovf_drained_level", {29'd0, level},    32'd0);
        tick();
        tick();
        chk("ovf_idle_tx",       {31'd0, tx},       32'd1);
        chk("ovf_sticky",        {31'd0, overflow}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        tick();
        tick();

        // simultaneous push/pop with level=1 in IDLE
        write_one(8'h3C);
        chk("pp_level_a", {29'd0, level}, 32'd1);
        write_one(8'hC3);
        chk("pp_level_b", {29'd0, level}, 32'd1);
        expect_frame(8'h3C, 0);
        chk("pp_gap_tx", {31'd0, tx}, 32'd1);
        tick();
        expect_frame(8'hC3, 0);
        tick();

        // reset during DATA bit 3 with two bytes queued
        wr_en = 1'b1;
        wr_data = 8'h55; tick();
        wr_data = 8'h66; tick();
        wr_data = 8'h77; tick();
        wr_en = 1'b0;
        chk("mid_level_q", {29'd0, level}, 32'd2);
        repeat (16) tick();
        chk("mid_tx_bit3", {31'd0, tx},   32'd0);
        chk("mid_busy",    {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_tx",    {31'd0, tx},    32'd1);
        chk("mid_rst_level", {29'd0, level}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy},  32'd0);
        #2;
        rst = 1'b1;
        for (int c = 0; c < 3 * CPB; c++) begin
            tick();
            chk($sformatf("mid_quiet_tx_%0d", c), {31'd0, tx}, 32'd1);
        end
        chk("mid_quiet_busy", {31'd0, busy}, 32'd0);

        // pointer wrap: 9 bytes, one at a time
        for (int i = 0; i < 9; i++) begin
            b = 8'h10 + 8'(i);
            write_one(b);
            chk($sformatf("wrap_level_%0d", i), {29'd0, level}, 32'd1);
            tick();
            expect_frame(b, 0);
            chk($sformatf("wrap_busy_%0d", i), {31'd0, busy}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_out_uart.md
# cpu_out_uart

Output stage downstream of the 8-bit processor core: captures each byte the core writes on its `OUT` instruction, buffers it in a small FIFO, and serialises it as 8N1 asynchronous serial (start bit, 8 data bits LSB first, one stop bit) on a single `tx` line. It decouples the single-cycle `OUT` write from the much slower serial bit rate, so the core can issue several `OUT` instructions back to back without waiting for the line.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal range ≥ 2.
- `FIFO_AW`, 2, FIFO address width; depth is 2**FIFO_AW (4 by default).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe from the core, asserted for one cycle per `OUT`.
- `wr_data`  in  8  byte to transmit; sampled when `wr_en` is 1.
- `full`  out  1  FIFO holds 2**FIFO_AW entries.
- `level`  out  FIFO_AW+1  current FIFO occupancy.
- `busy`  out  1  transmitter is not in IDLE.
- `overflow`  out  1  sticky flag; set when a write is dropped.
- `tx`  out  1  serial line; idles high.

## Operation
- **Reset** (`rst` low, asynchronous):
  - `tx`=1, `busy`=0, `full`=0, `level`=0, `overflow`=0.
  - FSM goes to IDLE; FIFO pointers, baud counter and bit counter clear.
  - Reset mid-frame abandons the frame: `tx` returns high immediately and the FIFO contents are discarded.
- **Push:** occurs on an edge where `wr_en`=1 and the registered `full`=0.
  - When `full`=1, the write is dropped and `overflow` is set. `overflow` is cleared only by reset.
  - A write while full is rejected even if a pop happens on the same edge.
- **Pop:** occurs only in IDLE, on an edge where the registered `level`≠0. The head byte loads into a 8-bit shift register.
  - A push and a pop on the same edge leave `level` unchanged.
  - A push into an empty FIFO cannot pop on the same edge.
- **FIFO pointers** are FIFO_AW bits and wrap modulo the depth. Occupancy is tracked by the FIFO_AW+1-bit `level`.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on pop. `tx`=1 in IDLE.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then → DATA.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit; shift right at the end of each bit. The 3-bit bit counter counts 0..7; after bit 7 → STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then → IDLE.
- **Counters:**
  - The baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and clears on every state or bit transition.
  - No arithmetic is performed on data.
- `tx` is driven from a register. There is no combinational path from `wr_en` to `tx`.

## Timing
- **Latency:** `wr_en` is sampled at edge k into an idle, empty block. Then `level`=1 after k, pop happens at k+1, and `tx` falls after k+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles, measured from the `tx` falling edge to the end of the stop bit.
- **Back to back:** a queued byte pops on the edge after STOP ends. Consecutive frames are therefore separated by exactly one IDLE cycle (`tx`=1).
- `busy` is 1 from the edge after pop until the edge that returns the FSM to IDLE.
- `full` and `level` update on the same edge as the push or pop.

## Structure
- **Shared package:** FSM state enum (IDLE/START/DATA/STOP) and the frame constants (DATA_BITS=8, STOP_BITS=1).
- **Sub-module `byte_fifo`:** synchronous single-clock FIFO parameterised by FIFO_AW, with push/pop/full/level. The top level contains only the FSM, the counters and the shift register.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, write 0xA5.
  - `tx` falls 2 cycles after `wr_en`.
  - Line sequence is 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles.
  - `busy` clears after 40 cycles.
- **Burst to full:** write 0x01..0x04 on consecutive cycles.
  - `full`=1 after the 4th write (or `level` peaks at 3, because the pop happens during the burst). Confirm `level` at each edge.
  - All 4 frames appear in order, each separated by one idle cycle.
- **Overflow:** write 6 bytes in consecutive cycles with depth 4.
  - The excess writes are dropped and `overflow`=1.
  - Only the accepted bytes appear on `tx`.
  - `overflow` stays 1 until `rst` is asserted.
- **Simultaneous push/pop:**
  - With `level`=1 in IDLE, write on the pop edge: `level` stays 1.
  - The second frame follows the first frame's stop bit plus one idle cycle.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 2 bytes queued.
  - `tx`=1 and `level`=0 immediately.
  - After release, `tx` stays high with no further frames.
- **Pointer wrap:** write and drain 9 bytes (0x10..0x18) one at a time.
  - All 9 are transmitted correctly across two pointer wraps.
